uart_event_link: RTL

//   Parametrised FPGA<->PC event link for an N-mole game. Turns game events (game-over,
//   hit, mole move) into ASCII bytes, queues them in a FIFO and feeds uart_tx with a

---
 rtl/whack_pkg.sv | 32 +++
 rtl/uart_event_link_if.sv | 27 ++
 rtl/uart_event_link_sync_fifo.sv | 56 +++++
 rtl/uart_event_link.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/whack_pkg.sv
// Shared constants for the whack-a-mole PC link.
// ASCII codes, TX FSM encodings and helpers.
package whack_pkg;

  localparam logic [7:0] CH_R    = 8'h52;
  localparam logic [7:0] CH_H    = 8'h48;
  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_C    = 8'h43;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_NONE = 8'h2D;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_WAIT_HI = 2'd2;
  localparam logic [1:0] S_WAIT_LO = 2'd3;

  typedef struct packed {
    logic r;
    logic h;
    logic m;
  } pend_t;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_event_link_if.sv
// Byte handshake between the event link and uart_tx/uart_rx.
// master = link side, slave = UART side.
interface uart_event_link_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       rx_ready;
  logic [7:0] rx_data;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  rx_ready,
    input  rx_data
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output rx_ready,
    output rx_data
  );

endinterface

// File: rtl/uart_event_link_sync_fifo.sv
// First-word fall-through FIFO with flush.
// A push on a full FIFO is accepted only alongside a pop.
module sync_fifo
  import whack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);
  assign rd_en = pop & !empty;
  assign wr_en = push & (!full | rd_en);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // storage array, written at the tail
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // head/tail pointers; flush empties the queue
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_event_link.sv
// Game events -> ASCII bytes -> FIFO -> uart_tx.
// PC bytes from uart_rx decode into start/hit pulses.
module uart_event_link
  import whack_pkg::*;
#(
  parameter int NUM_MOLES    = 5,
  parameter int FIFO_DEPTH   = 8,
  parameter int BUSY_TIMEOUT = 4,
  parameter int OVF_W        = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       game_active,
  input  logic                       game_finish,
  input  logic                       hit_pulse,
  input  logic [NUM_MOLES-1:0]       mole_positions,
  uart_event_link_if.master          uart,
  output logic                       pc_start,
  output logic                       pc_hit,
  output logic [clog2(FIFO_DEPTH):0] fifo_level,
  output logic [OVF_W-1:0]           overflow_count
);

  localparam int TW = clog2(BUSY_TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(BUSY_TIMEOUT - 1);

  pend_t                pend;
  pend_t                take;
  logic                 go_sent;
  logic [NUM_MOLES-1:0] last_mole;
  logic                 set_r;
  logic                 set_h;
  logic                 set_m;
  logic                 idle_clr;
  logic                 flush;
  logic                 sel_h;
  logic                 sel_m;
  logic [7:0]           mole_ch;
  logic [7:0]           q_byte;
  logic                 q_push;
  logic                 q_full;
  logic                 q_empty;
  logic [7:0]           q_rdata;
  logic                 pop_go;
  logic                 drop;
  logic [1:0]           state;
  logic [TW-1:0]        wait_cnt;

  assign flush    = uart.rx_ready & (uart.rx_data == CH_C);
  assign set_r    = game_finish & !go_sent;
  assign set_h    = hit_pulse;
  assign set_m    = game_active & (mole_positions != last_mole);
  assign idle_clr = !game_active & !game_finish;
  assign sel_h    = !pend.r & pend.h;
  assign sel_m    = !pend.r & !pend.h & pend.m;

  assign pop_go = (state == S_IDLE) & !q_empty
                & !uart.tx_busy & !flush;
  assign q_push = (|take) & !flush;
  assign drop   = q_push & q_full & !pop_go;

  assign uart.tx_start = (state == S_START);

  // lowest active mole index as a digit, '-' when none
  always_comb begin
    mole_ch = CH_NONE;
    for (int i = NUM_MOLES - 1; i >= 0; i--) begin
      if (last_mole[i]) mole_ch = CH_ZERO + 8'(i);
    end
  end

  // pick one pending event per cycle, R over H over M
  always_comb begin
    take   = '0;
    q_byte = CH_R;
    unique case (1'b1)
      pend.r: take.r = 1'b1;
      sel_h: begin
        take.h = 1'b1;
        q_byte = CH_H;
      end
      sel_m: begin
        take.m = 1'b1;
        q_byte = mole_ch;
      end
      default: ;
    endcase
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (q_push),
    .pop   (pop_go),
    .flush (flush),
    .wdata (q_byte),
    .rdata (q_rdata),
    .full  (q_full),
    .empty (q_empty),
    .level (fifo_level)
  );

  // event capture, pending merge and overflow accounting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend           <= '0;
      go_sent        <= 1'b0;
      last_mole      <= '0;
      overflow_count <= '0;
    end else begin
      if (flush) begin
        pend <= '0;
      end else begin
        pend.r <= (pend.r & !take.r) | set_r;
        pend.h <= (pend.h & !take.h) | set_h;
        pend.m <= ((pend.m & !take.m) | set_m)
                & !idle_clr;
      end
      if (set_r) go_sent <= 1'b1;
      else if (idle_clr) go_sent <= 1'b0;
      if (idle_clr) last_mole <= '0;
      else if (set_m) last_mole <= mole_positions;
      if (drop && overflow_count != '1)
        overflow_count <= overflow_count + 1'b1;
    end
  end

  // TX launch sequencer with busy-rise timeout
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      uart.tx_data <= '0;
      wait_cnt     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop_go) begin
            uart.tx_data <= q_rdata;
            state        <= S_START;
          end
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (uart.tx_busy) state <= S_WAIT_LO;
          else if (wait_cnt == T_LAST) state <= S_IDLE;
          else wait_cnt <= wait_cnt + 1'b1;
        end
        S_WAIT_LO: begin
          if (!uart.tx_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // PC command decode, one pulse per received byte
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_start <= 1'b0;
      pc_hit   <= 1'b0;
    end else begin
      pc_start <= uart.rx_ready & (uart.rx_data == CH_S);
      pc_hit   <= uart.rx_ready & (uart.rx_data == CH_H);
    end
  end

endmodule
